uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Drives the output mux select, serializer shift enable and accept strobe, so that each accepted byte is sent as start, DATA_WIDTH data bits LSB first, optional parity, then stop.
- Sits between the upstream parallel-data source and the serializer, parity unit and output mux.
- One bit time per CLK cycle; CLK is the TX bit clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).
- CNT_W, $clog2(DATA_WIDTH), width of the internal bit counter.

Ports:
- CLK  input  1  TX bit clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-low reset, sampled on rising CLK.
- DATA_VALID  input  1  upstream has a byte ready on its parallel bus.
- PAR_EN  input  1  include a parity bit in the frame; sampled only at accept.
- ACCEPT  output  1  combinational; DATA_VALID && state==IDLE && RST; serializer and parity unit capture P_DATA on this cycle.
- SER_EN  output  1  serializer shift enable, high during data bits.
- MUX_SEL  output  2  output mux select: 00 start (0), 01 stop/idle (1), 10 serial data, 11 parity.
- BUSY  output  1  frame in progress.
- FRAME_DONE  output  1  one-cycle pulse during the stop bit.

Behaviour:
- Reset (RST=0 at a rising edge): state=IDLE, bit counter=0, latched par_en_q=0.
  - Outputs after reset: MUX_SEL=01, SER_EN=0, BUSY=0, FRAME_DONE=0.
  - ACCEPT is forced 0 while RST=0.
- Output timing:
  - MUX_SEL, SER_EN, BUSY and FRAME_DONE are Moore outputs decoded from the state register only; no input-to-output combinational path.
  - ACCEPT is the only combinational output.
  - The output mux adds one register stage, so the line lags MUX_SEL by one cycle.
- IDLE:
  - MUX_SEL=01, BUSY=0.
  - If DATA_VALID=1: ACCEPT=1, par_en_q<=PAR_EN, next state START.
- START:
  - MUX_SEL=00, BUSY=1.
  - Counter<=0; next state DATA.
- DATA:
  - MUX_SEL=10, SER_EN=1, BUSY=1.
  - Counter increments each cycle.
  - When counter==DATA_WIDTH-1: next state PARITY if par_en_q, else STOP; counter<=0.
  - Exactly DATA_WIDTH cycles are spent in DATA.
- PARITY:
  - MUX_SEL=11, BUSY=1, SER_EN=0.
  - Next state STOP.
- STOP:
  - MUX_SEL=01, BUSY=1, FRAME_DONE=1.
  - Next state IDLE, unless the optional feature applies.
- Frame length: 2+DATA_WIDTH cycles, plus 1 when parity is enabled.
  - Minimum accept-to-accept spacing is frame length + 1 cycle, for the IDLE cycle.
- Boundary conditions:
  - DATA_VALID while BUSY is ignored; there is no queuing and ACCEPT stays 0.
  - PAR_EN changes mid-frame have no effect on the frame in progress.
  - Reset mid-frame forces IDLE, MUX_SEL=01 and counter=0 at the next edge. The partial frame is abandoned with no FRAME_DONE.
  - Unreachable state encodings recover to IDLE on the next edge.
  - The counter never exceeds DATA_WIDTH-1.

Optional Feature:
- Macro: UART_TX_BACK2BACK_EN.
- When defined:
  - In STOP, if DATA_VALID=1, then ACCEPT=1, par_en_q<=PAR_EN, and next state is START, skipping IDLE.
  - BUSY stays 1 across frames, giving zero-gap back-to-back frames.
  - ACCEPT becomes DATA_VALID && (state==IDLE || state==STOP).
- When undefined:
  - STOP always goes to IDLE.
  - ACCEPT is asserted in IDLE only.

Test Plan:
- Reset: RST=0 for 2 cycles with DATA_VALID=1 -> ACCEPT=0, MUX_SEL=01, BUSY=0, SER_EN=0 throughout; no state change.
- Frame without parity: DATA_WIDTH=8, PAR_EN=0, DATA_VALID pulse in IDLE -> ACCEPT 1 cycle, then MUX_SEL sequence 00, 10×8 (SER_EN=1 on exactly those 8 cycles), 01 with FRAME_DONE=1; BUSY high 10 cycles.
- Frame with parity: PAR_EN=1 at accept, then PAR_EN=0 mid-frame -> sequence 00, 10×8, 11, 01; BUSY high 11 cycles.
- Request while busy: DATA_VALID held high continuously -> ACCEPT only in IDLE cycles, one every 11 cycles (PAR_EN=0) without UART_TX_BACK2BACK_EN; every 10 cycles with it, BUSY never dropping.
- Reset mid-frame: RST=0 during the 4th data bit -> next cycle state IDLE, MUX_SEL=01, BUSY=0, no FRAME_DONE; the following DATA_VALID starts a clean frame with counter from 0.
- DATA_WIDTH=5 with parity: one frame -> exactly 5 SER_EN cycles, parity bit, stop; total BUSY 8 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Steps each accepted byte through start, DATA_WIDTH data bits (LSB first),
// optional parity and stop, one bit per CLK cycle, by driving the output mux
// select and serializer shift enable.
// Optional build macro UART_TX_BACK2BACK_EN: accept a new byte during the stop
// bit and go straight to the next start bit with no idle gap.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  output logic       ACCEPT,
  output logic       SER_EN,
  output logic [1:0] MUX_SEL,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MuxStart  = 2'b00;
  localparam logic [1:0] MuxStop   = 2'b01;
  localparam logic [1:0] MuxData   = 2'b10;
  localparam logic [1:0] MuxParity = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic             ser_en_q, ser_en_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  // Accept strobe: the only combinational output; gated by reset.
`ifdef UART_TX_BACK2BACK_EN
  assign ACCEPT = DATA_VALID && RST && ((state_q == StIdle) || (state_q == StStop));
`else
  assign ACCEPT = DATA_VALID && RST && (state_q == StIdle);
`endif

  // Next-state and bit-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    case (state_q)
      StIdle: begin
        if (ACCEPT) begin
          par_en_d = PAR_EN;
          state_d  = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = par_en_q ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StParity: state_d = StStop;
      StStop: begin
`ifdef UART_TX_BACK2BACK_EN
        if (ACCEPT) begin
          par_en_d = PAR_EN;
          state_d  = StStart;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: begin
        // Unused encodings fall back to idle.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode from the next state so the outputs register with it.
  always_comb begin
    mux_sel_d    = MuxStop;
    ser_en_d     = 1'b0;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;
    case (state_d)
      StIdle:   busy_d = 1'b0;
      StStart:  mux_sel_d = MuxStart;
      StData: begin
        mux_sel_d = MuxData;
        ser_en_d  = 1'b1;
      end
      StParity: mux_sel_d = MuxParity;
      StStop:   frame_done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  // State, counter, latched parity enable and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      par_en_q     <= 1'b0;
      mux_sel_q    <= MuxStop;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      par_en_q     <= par_en_d;
      mux_sel_q    <= mux_sel_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign MUX_SEL    = mux_sel_q;
  assign SER_EN     = ser_en_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule
